// File: rtl/oscillator_phase_reader.sv
// oscillator_phase_reader
//   Reads the phase of N free-running oscillators against a reference
//   oscillator. Every input is synchronized into clk. Over a window of
//   2^WINDOW_BITS cycles it counts, per oscillator, the cycles that disagree
//   with the reference. Each count is then thresholded into a spin bit and
//   handed to the annealing controller with a valid/ready handshake.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   osc_in[N]     asynchronous oscillator outputs
//   ref_in        asynchronous reference oscillator output
//   start         request a measurement (sampled in IDLE and HOLD only)
//   busy          high in SETTLE and MEASURE
//   result_valid  high in HOLD
//   result_ready  consumer accepts the result
//   spin[N]       1 = oscillator anti-phase to the reference
//   count_sel     selects the mismatch counter shown on count_out
//   count_out     mismatch count of the selected oscillator (0 if sel >= N)
//   ref_edges     reference rising edges seen in the window
//
// Build option
//   OSC_PHASE_READER_REF_EDGE_COUNT_EN : enables the reference edge counter.
//   When it is not defined, ref_edges is tied to 0.

module oscillator_phase_reader #(
    parameter int N           = 16,
    parameter int WINDOW_BITS = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           osc_in,
    input  logic                   ref_in,
    input  logic                   start,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [N-1:0]           spin,
    input  logic [$clog2(N)-1:0]   count_sel,
    output logic [WINDOW_BITS:0]   count_out,
    output logic [WINDOW_BITS-1:0] ref_edges
);

    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);
    localparam logic [WINDOW_BITS:0] HALF_CNT = (WINDOW_BITS+1)'(1) << (WINDOW_BITS - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, HOLD} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0][N-1:0] osc_sync;
    logic [SYNC_STAGES-1:0]        ref_sync;
    logic [N-1:0]                  osync;
    logic                          rsync;

    logic [SETTLE_W-1:0]           settle_cnt;
    logic [WINDOW_BITS-1:0]        win_cnt;
    logic [N-1:0][WINDOW_BITS:0]   cnt;
    logic [N-1:0][WINDOW_BITS:0]   cnt_next;
    logic                          start_meas;
    logic                          settle_done;
    logic                          win_last;

    // Synchronizer chains; the last stage is the only one used downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            osc_sync <= '0;
            ref_sync <= '0;
        end else begin
            osc_sync[0] <= osc_in;
            ref_sync[0] <= ref_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                osc_sync[s] <= osc_sync[s-1];
                ref_sync[s] <= ref_sync[s-1];
            end
        end
    end

    assign osync = osc_sync[SYNC_STAGES-1];
    assign rsync = ref_sync[SYNC_STAGES-1];

    // SETTLE spans SYNC_STAGES+1 cycles so that the first counted sample was
    // captured by the first stage strictly after start was accepted.
    assign settle_done = (settle_cnt == SETTLE_W'(SYNC_STAGES));
    assign win_last    = &win_cnt;

    always_comb begin
        state_d      = state_q;
        start_meas   = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    start_meas = 1'b1;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_done) state_d = MEASURE;
            end
            MEASURE: begin
                busy = 1'b1;
                if (win_last) state_d = HOLD;
            end
            HOLD: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    if (start) begin
                        state_d    = SETTLE;
                        start_meas = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter value including this cycle's sample, so the threshold taken on
    // the last window cycle sees the full count.
    always_comb begin
        for (int i = 0; i < N; i++)
            cnt_next[i] = cnt[i] + {{WINDOW_BITS{1'b0}}, osync[i] ^ rsync};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            settle_cnt <= '0;
            win_cnt    <= '0;
            cnt        <= '0;
            spin       <= '0;
        end else begin
            state_q <= state_d;
            if (start_meas) begin
                settle_cnt <= '0;
                win_cnt    <= '0;
                cnt        <= '0;
            end else begin
                if (state_q == SETTLE) settle_cnt <= settle_cnt + 1'b1;
                if (state_q == MEASURE) begin
                    win_cnt <= win_cnt + 1'b1;
                    cnt     <= cnt_next;
                end
            end
            if (state_q == MEASURE && win_last) begin
                for (int i = 0; i < N; i++)
                    spin[i] <= (cnt_next[i] > HALF_CNT);
            end
        end
    end

    always_comb begin
        count_out = '0;
        if (int'(count_sel) < N) count_out = cnt[count_sel];
    end

`ifdef OSC_PHASE_READER_REF_EDGE_COUNT_EN
    logic                   rsync_d;
    logic [WINDOW_BITS-1:0] edges_q;

    // rsync_d tracks every cycle so the first window cycle already has a
    // valid previous sample to detect an edge against.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsync_d <= 1'b0;
            edges_q <= '0;
        end else begin
            rsync_d <= rsync;
            if (start_meas)
                edges_q <= '0;
            else if (state_q == MEASURE && rsync && !rsync_d && !(&edges_q))
                edges_q <= edges_q + 1'b1;
        end
    end

    assign ref_edges = edges_q;
`else
    assign ref_edges = '0;
`endif

endmodule

// File: tb/tb_oscillator_phase_reader.sv
module tb_oscillator_phase_reader;

    localparam int N   = 4;
    localparam int WB  = 4;
    localparam int SS  = 2;
    localparam int WIN = 1 << WB;
    localparam int LAT = 1 + SS + WIN;

    logic              clk;
    logic              rst;
    logic [N-1:0]      osc_in;
    logic              ref_in;
    logic              start;
    logic              busy;
    logic              result_valid;
    logic              result_ready;
    logic [N-1:0]      spin;
    logic [$clog2(N)-1:0] count_sel;
    logic [WB:0]       count_out;
    logic [WB-1:0]     ref_edges;

    int total = 0;
    int bad   = 0;

    oscillator_phase_reader #(.N(N), .WINDOW_BITS(WB), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .osc_in(osc_in), .ref_in(ref_in), .start(start),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .spin(spin), .count_sel(count_sel), .count_out(count_out),
        .ref_edges(ref_edges)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A measurement accepted at edge t uses the inputs sampled at edges
    // t+2 .. t+1+WIN and completes at edge t+LAT.
    logic [N-1:0] osc_h [0:8191];
    logic         ref_h [0:8191];
    int           edge_n = 0;
    int           ph = 0;       // 0 idle, 1 busy, 2 holding a result
    int           m_t = 0;
    logic [WB:0]  m_cnt [N];
    logic [N-1:0] m_spin;
    logic [WB-1:0] m_edges;

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_cnt[i] = '0;
        m_edges = '0;
    endtask

    task automatic model_finish();
        int e;
        for (int i = 0; i < N; i++) begin
            int c = 0;
            for (int j = m_t + 2; j <= m_t + 1 + WIN; j++)
                if (osc_h[j][i] != ref_h[j]) c++;
            m_cnt[i]  = (WB+1)'(c);
            m_spin[i] = (2 * c > WIN);
        end
        e = 0;
`ifdef OSC_PHASE_READER_REF_EDGE_COUNT_EN
        for (int j = m_t + 2; j <= m_t + 1 + WIN; j++)
            if (ref_h[j] && !ref_h[j-1]) e++;
        if (e > WIN - 1) e = WIN - 1;
`endif
        m_edges = WB'(e);
    endtask

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        osc_h[edge_n] = osc_in;
        ref_h[edge_n] = ref_in;
        if (rst) begin
            ph = 0;
            m_spin = '0;
            model_clear();
        end else if (ph == 0) begin
            if (start) begin ph = 1; m_t = edge_n; model_clear(); end
        end else if (ph == 1) begin
            if (edge_n == m_t + LAT) begin model_finish(); ph = 2; end
        end else begin
            if (result_ready) begin
                if (start) begin ph = 1; m_t = edge_n; model_clear(); end
                else ph = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (edge_n > 0) begin
            chk("busy", 32'(busy), 32'(ph == 1));
            chk("result_valid", 32'(result_valid), 32'(ph == 2));
            chk("spin", 32'(spin), 32'(m_spin));
            if (ph != 1) begin
                chk("count_out", 32'(count_out), 32'((int'(count_sel) < N) ? m_cnt[count_sel] : '0));
                chk("ref_edges", 32'(ref_edges), 32'(m_edges));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs sampled at edge t+k of a measurement started at edge t.
    task automatic drive(input int mode, input int k);
        logic r;
        r = 1'b0;
        case (mode)
            0: begin r = ((k / 3) % 2) != 0; ref_in = r; osc_in = {N{r}}; end
            1: begin r = ((k / 3) % 2) != 0; ref_in = r; osc_in = {N{r}}; osc_in[0] = ~r; end
            2: begin r = (k % 2) != 0; ref_in = r; osc_in = {N{r}}; osc_in[2] = 1'b1; end
            3: begin
                r = (k % 2) != 0; ref_in = r; osc_in = {N{r}};
                if (k >= 2 && k <= 10) osc_in[2] = ~r;
            end
            5: begin r = ((k / 2) % 2) != 0; ref_in = r; osc_in = {N{r}}; end
            default: begin
                osc_in    = N'($urandom);
                ref_in    = 1'($urandom);
                count_sel = 2'($urandom);
            end
        endcase
    endtask

    task automatic measure(input int mode, input bit b2b);
        start = 1'b1;
        if (b2b) result_ready = 1'b1;
        drive(mode, 0);
        step();
        start = 1'b0;
        result_ready = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_rv", 32'(result_valid), 32'd0);
        if (b2b) chk("b2b_cnt_clear", 32'(count_out), 32'd0);
        for (int k = 1; k <= LAT; k++) begin
            drive(mode, k);
            step();
            if (k == LAT - 1) chk("early_rv", 32'(result_valid), 32'd0);
        end
        chk("latency_rv", 32'(result_valid), 32'd1);
        chk("latency_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_sel(input int sel, input int exp);
        count_sel = 2'(sel);
        #1;
        chk("count_sel", 32'(count_out), 32'(exp));
    endtask

    task automatic release_hold();
        result_ready = 1'b1;
        start = 1'b0;
        step();
        result_ready = 1'b0;
        chk("release_rv", 32'(result_valid), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        bit in_hold;
        rst = 1'b1; start = 1'b1; result_ready = 1'b1;
        osc_in = '0; ref_in = 1'b0; count_sel = '0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_spin", 32'(spin), 32'd0);
        chk("rst_cnt", 32'(count_out), 32'd0);
        chk("rst_edges", 32'(ref_edges), 32'd0);
        rst = 1'b0; start = 1'b0; result_ready = 1'b0;
        step();

        measure(0, 0);
        chk("in_phase_spin", 32'(spin), 32'd0);
        for (int s = 0; s < N; s++) chk_sel(s, 0);
        release_hold();

        measure(1, 0);
        chk("anti0_spin", 32'(spin), 32'b0001);
        chk_sel(0, 16);
        for (int s = 1; s < N; s++) chk_sel(s, 0);
        release_hold();

        measure(2, 0);
        chk_sel(2, 8);
        chk("tie_spin", 32'(spin), 32'd0);
        release_hold();

        measure(3, 0);
        chk_sel(2, 9);
        chk("nine_spin", 32'(spin), 32'b0100);
        release_hold();

        // reset in the fifth MEASURE cycle
        start = 1'b1; drive(4, 0); step(); start = 1'b0;
        for (int k = 1; k <= SS + 1 + 4; k++) begin drive(4, k); step(); end
        chk("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rv", 32'(result_valid), 32'd0);
        chk("mid_rst_spin", 32'(spin), 32'd0);
        chk("mid_rst_cnt", 32'(count_out), 32'd0);
        measure(4, 0);

        // consumer stalls with start pulses
        for (int c = 0; c < 10; c++) begin
            start = 1'($urandom);
            result_ready = 1'b0;
            step();
            chk("stall_rv", 32'(result_valid), 32'd1);
            chk("stall_busy", 32'(busy), 32'd0);
            chk("stall_spin", 32'(spin), 32'(m_spin));
        end
        release_hold();

        measure(4, 0);
        measure(5, 1);
`ifdef OSC_PHASE_READER_REF_EDGE_COUNT_EN
        chk("ref_edges_lit", 32'(ref_edges), 32'd4);
`else
        chk("ref_edges_lit", 32'(ref_edges), 32'd0);
`endif
        release_hold();

        in_hold = 1'b0;
        for (int it = 0; it < 8; it++) begin
            measure(4, in_hold);
            if ($urandom_range(0, 1) == 1) begin
                in_hold = 1'b1;
                repeat ($urandom_range(0, 3)) begin count_sel = 2'($urandom); step(); end
            end else begin
                release_hold();
                in_hold = 1'b0;
                repeat ($urandom_range(0, 3)) begin count_sel = 2'($urandom); step(); end
            end
        end
        if (in_hold) release_hold();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
